// File: rtl/bcd_7seg_scan_driver.sv
// 3-digit multiplexed 7-segment scan driver with tear-free digit updates.
// Ports: clk, rst (async high), load + hundreds_in/tens_in/ones_in (BCD),
//        seg_out {g..a}, an_out {hund,tens,ones}, frame_done (1-cycle pulse).
module bcd_7seg_scan_driver #(
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hundreds_in,
    input  logic [3:0] tens_in,
    input  logic [3:0] ones_in,
    output logic [6:0] seg_out,
    output logic [2:0] an_out,
    output logic       frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'h7 : 3'h0;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_HUND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [PW-1:0] r_presc;
    logic [3:0]    r_disp_h, r_disp_t, r_disp_o;
    logic [3:0]    r_pend_h, r_pend_t, r_pend_o;
    logic          r_pend_flag;

    logic          w_tick;
    logic          w_bound;
    logic [3:0]    w_dig;
    logic          w_blank;
    logic [6:0]    w_seg_hi;
    logic [2:0]    w_an_hi;

    function automatic logic [6:0] f_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign w_tick  = (r_presc == PW'(CLK_DIV - 1));
    assign w_bound = w_tick && (r_state == S_HUND);

    // Prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ONES;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_tick) begin
            case (r_state)
                S_ONES:  w_state_nx = S_TENS;
                S_TENS:  w_state_nx = S_HUND;
                S_HUND:  w_state_nx = S_ONES;
                default: w_state_nx = S_ONES;
            endcase
        end
    end

    // Digits are double-buffered; the visible set only changes when a
    // frame wraps so a scan never mixes old and new digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_h    <= '0;
            r_disp_t    <= '0;
            r_disp_o    <= '0;
            r_pend_h    <= '0;
            r_pend_t    <= '0;
            r_pend_o    <= '0;
            r_pend_flag <= 1'b0;
        end else if (load && w_bound) begin
            r_disp_h    <= hundreds_in;
            r_disp_t    <= tens_in;
            r_disp_o    <= ones_in;
            r_pend_h    <= hundreds_in;
            r_pend_t    <= tens_in;
            r_pend_o    <= ones_in;
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_pend_h    <= hundreds_in;
            r_pend_t    <= tens_in;
            r_pend_o    <= ones_in;
            r_pend_flag <= 1'b1;
        end else if (w_bound && r_pend_flag) begin
            r_disp_h    <= r_pend_h;
            r_disp_t    <= r_pend_t;
            r_disp_o    <= r_pend_o;
            r_pend_flag <= 1'b0;
        end
    end

    // Slot decode from the current state (before any advance)
    always_comb begin
        w_dig   = r_disp_o;
        w_an_hi = 3'b001;
        w_blank = 1'b0;
        case (r_state)
            S_TENS: begin
                w_dig   = r_disp_t;
                w_an_hi = 3'b010;
                w_blank = BLANK_LZ && (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
            end
            S_HUND: begin
                w_dig   = r_disp_h;
                w_an_hi = 3'b100;
                w_blank = BLANK_LZ && (r_disp_h == 4'd0);
            end
            default: begin
                w_dig   = r_disp_o;
                w_an_hi = 3'b001;
                w_blank = 1'b0;
            end
        endcase
        w_seg_hi = w_blank ? 7'h00 : f_dec(w_dig);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= SEG_OFF;
            an_out     <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
            an_out     <= SEG_ACTIVE_LOW ? ~w_an_hi : w_an_hi;
            frame_done <= w_bound;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomized + directed bench for bcd_7seg_scan_driver against a cycle-count model.
// Two DUTs: active-low with blanking, and active-high without blanking.
module tb_bcd_7seg_scan_driver;

    localparam int DIV = 4;
    localparam int FRM = 3 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] hundreds_in, tens_in, ones_in;
    logic [6:0] seg_a, seg_b;
    logic [2:0] an_a, an_b;
    logic       fd_a, fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int         c;
    logic [3:0] mh, mt, mo, ph, pt, po;
    bit         pf;
    logic [6:0] e_seg_a, e_seg_b;
    logic [2:0] e_an_a, e_an_b;
    logic       e_fd;

    logic [6:0] pat [16];

    always #5 clk = ~clk;

    bcd_7seg_scan_driver #(
        .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .load(load),
        .hundreds_in(hundreds_in), .tens_in(tens_in), .ones_in(ones_in),
        .seg_out(seg_a), .an_out(an_a), .frame_done(fd_a)
    );

    bcd_7seg_scan_driver #(
        .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .load(load),
        .hundreds_in(hundreds_in), .tens_in(tens_in), .ones_in(ones_in),
        .seg_out(seg_b), .an_out(an_b), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s c=%0d got=%h want=%h", tag, c, obs, exp);
        end
    endtask

    // Expected active-high segments for a slot (0=ones,1=tens,2=hund)
    function automatic logic [6:0] hi_seg(input int slot, input bit blz);
        logic [3:0] d;
        bit blank;
        d = (slot == 0) ? mo : (slot == 1) ? mt : mh;
        blank = blz && ((slot == 2 && mh == 0) || (slot == 1 && mh == 0 && mt == 0));
        return blank ? 7'h00 : pat[d];
    endfunction

    task automatic model_reset();
        c = 0;
        {mh, mt, mo, ph, pt, po} = '0;
        pf = 0;
    endtask

    // One clock edge: c is the number of edges since reset release
    task automatic model_edge(input bit ld, input logic [3:0] h, t, o);
        int slot;
        bit bnd;
        logic [2:0] an1;
        slot = (c / DIV) % 3;
        bnd  = (c % FRM) == FRM - 1;
        an1  = 3'(1 << slot);
        e_seg_a = ~hi_seg(slot, 1'b1);
        e_an_a  = ~an1;
        e_seg_b = hi_seg(slot, 1'b0);
        e_an_b  = an1;
        e_fd    = bnd;
        if (ld && bnd) begin
            mh = h; mt = t; mo = o; pf = 0;
        end else if (ld) begin
            ph = h; pt = t; po = o; pf = 1;
        end else if (bnd && pf) begin
            mh = ph; mt = pt; mo = po; pf = 0;
        end
        c++;
    endtask

    task automatic check_all();
        chk("seg_a", 8'(seg_a), 8'(e_seg_a));
        chk("an_a",  8'(an_a),  8'(e_an_a));
        chk("fd_a",  8'(fd_a),  8'(e_fd));
        chk("seg_b", 8'(seg_b), 8'(e_seg_b));
        chk("an_b",  8'(an_b),  8'(e_an_b));
        chk("fd_b",  8'(fd_b),  8'(e_fd));
    endtask

    task automatic check_off(input string tag);
        chk({tag, "_seg_a"}, 8'(seg_a), 8'h7F);
        chk({tag, "_an_a"},  8'(an_a),  8'h07);
        chk({tag, "_seg_b"}, 8'(seg_b), 8'h00);
        chk({tag, "_an_b"},  8'(an_b),  8'h00);
        chk({tag, "_fd"},    8'({fd_a, fd_b}), 8'h00);
    endtask

    // Called between edges (after negedge)
    task automatic step(input bit ld, input logic [3:0] h, t, o);
        load = ld; hundreds_in = h; tens_in = t; ones_in = o;
        @(posedge clk);
        model_edge(ld, h, t, o);
        @(negedge clk);
        check_all();
    endtask

    // Idle with random garbage on the digit inputs
    task automatic idle_to(input int target);
        while (c < target)
            step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic ld_at(input int target, input logic [3:0] h, t, o);
        idle_to(target);
        step(1'b1, h, t, o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_off("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_off("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        rst = 1'b1;
        load = 1'b0;
        {hundreds_in, tens_in, ones_in} = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_off("reset");
        rst = 1'b0;

        idle_to(24);
        ld_at(29, 4'd1, 4'd2, 4'd3);
        idle_to(48);
        ld_at(50, 4'd0, 4'd4, 4'd5);
        ld_at(55, 4'd2, 4'd0, 4'd7);
        idle_to(72);
        ld_at(83, 4'd0, 4'd0, 4'd7);
        idle_to(108);
        ld_at(110, 4'd0, 4'd12, 4'd5);
        idle_to(132);
        ld_at(135, 4'd9, 4'd9, 4'd9);
        idle_to(138);
        do_reset();
        idle_to(24);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            if ($urandom_range(0, 5) == 0)
                step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            else
                step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
